// File: rtl/data_ram_responder_pkg.sv
// Shared types and helpers for the data RAM responder: FSM encoding and
// the per-byte write-first merge used by both read ports.
package data_ram_responder_pkg;

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_RUN   = 1'b1
  } ram_state_e;

  localparam int          DEFAULT_AW   = 8;
  localparam logic [31:0] DEFAULT_BASE = 32'h0000_0000;

  // Lanes flagged in lane_we take the incoming byte, the rest keep the stored byte.
  function automatic logic [31:0] lane_merge(input logic [31:0] stored,
                                             input logic [3:0]  lane_we,
                                             input logic [31:0] wdata);
    logic [31:0] r;
    r = stored;
    for (int i = 0; i < 4; i++) begin
      if (lane_we[i]) r[8*i +: 8] = wdata[8*i +: 8];
    end
    return r;
  endfunction

endpackage

// File: rtl/data_ram_responder_byte_lane_ram.sv
// DEPTH x 32 storage with four byte write enables and two synchronous,
// write-first read ports. Read enables low load zero into the output registers.
module data_ram_responder_byte_lane_ram
  import data_ram_responder_pkg::*;
#(
  parameter int AW = DEFAULT_AW
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [3:0]    we,
  input  logic [AW-1:0] waddr,
  input  logic [31:0]   wdata,
  input  logic          ren_a,
  input  logic [AW-1:0] raddr_a,
  output logic [31:0]   q_a,
  input  logic          ren_b,
  input  logic [AW-1:0] raddr_b,
  output logic [31:0]   q_b
);

  logic [31:0] mem [(1<<AW)];
  logic [3:0]  lane_hit_a;
  logic [3:0]  lane_hit_b;

  // The array itself is never reset; only the output registers are.
  always_ff @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (we[i]) mem[waddr][8*i +: 8] <= wdata[8*i +: 8];
    end
  end

  assign lane_hit_a = (waddr == raddr_a) ? we : 4'b0000;
  assign lane_hit_b = (waddr == raddr_b) ? we : 4'b0000;

  always_ff @(posedge clk) begin
    if (rst) begin
      q_a <= 32'h0;
      q_b <= 32'h0;
    end else begin
      q_a <= ren_a ? lane_merge(mem[raddr_a], lane_hit_a, wdata) : 32'h0;
      q_b <= ren_b ? lane_merge(mem[raddr_b], lane_hit_b, wdata) : 32'h0;
    end
  end

endmodule

// File: rtl/data_ram_responder.sv
// MEM-stage data RAM responder: clear sequencer, window decode, write-source
// mux and fault flag around a byte-lane RAM with a CPU port and a display port.
module data_ram_responder
  import data_ram_responder_pkg::*;
#(
  parameter int          AW             = DEFAULT_AW,
  parameter logic [31:0] BASE_ADDR      = DEFAULT_BASE,
  parameter bit          CLEAR_ON_RESET = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] dm_addr,
  input  logic [3:0]  dm_wen,
  input  logic [31:0] dm_wdata,
  output logic [31:0] dm_rdata,
  output logic        addr_fault,
  output logic        ram_ready,
  input  logic [31:0] test_addr,
  output logic [31:0] test_data
);

  ram_state_e    state;
  logic [AW-1:0] clr_cnt;

  logic          cpu_hit;
  logic          tst_hit;
  logic [AW-1:0] cpu_idx;
  logic [AW-1:0] tst_idx;

  logic [3:0]    ram_we;
  logic [AW-1:0] ram_waddr;
  logic [31:0]   ram_wdata;
  logic          run;

  logic          unused_addr_bits;
  assign unused_addr_bits = ^{dm_addr[1:0], test_addr[1:0]};

  assign cpu_hit = (dm_addr[31:AW+2] == BASE_ADDR[31:AW+2]);
  assign tst_hit = (test_addr[31:AW+2] == BASE_ADDR[31:AW+2]);
  assign cpu_idx = dm_addr[AW+1:2];
  assign tst_idx = test_addr[AW+1:2];

  assign run       = (state == ST_RUN);
  assign ram_ready = run;

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= CLEAR_ON_RESET ? ST_CLEAR : ST_RUN;
      clr_cnt    <= '0;
      addr_fault <= 1'b0;
    end else begin
      case (state)
        ST_CLEAR: begin
          clr_cnt    <= clr_cnt + 1'b1;
          addr_fault <= 1'b0;
          if (&clr_cnt) state <= ST_RUN;
        end
        ST_RUN: begin
          addr_fault <= ~cpu_hit;
        end
        default: state <= ST_CLEAR;
      endcase
    end
  end

  // While clearing, the sequencer owns the write port and CPU stores are dropped.
  always_comb begin
    ram_we    = 4'b0000;
    ram_waddr = cpu_idx;
    ram_wdata = dm_wdata;
    if (!run) begin
      ram_we    = 4'b1111;
      ram_waddr = clr_cnt;
      ram_wdata = 32'h0;
    end else if (cpu_hit) begin
      ram_we = dm_wen;
    end
  end

  data_ram_responder_byte_lane_ram #(.AW(AW)) u_ram (
    .clk     (clk),
    .rst     (reset),
    .we      (ram_we),
    .waddr   (ram_waddr),
    .wdata   (ram_wdata),
    .ren_a   (run && cpu_hit),
    .raddr_a (cpu_idx),
    .q_a     (dm_rdata),
    .ren_b   (run && tst_hit),
    .raddr_b (tst_idx),
    .q_b     (test_data)
  );

endmodule

// File: tb/tb_data_ram_responder.sv
// Directed and randomized checks of data_ram_responder against an array model
// of the data window (AW=8, base 0).
module tb_data_ram_responder;

  localparam int          AW    = 8;
  localparam int          DEPTH = 1 << AW;
  localparam logic [31:0] BASE  = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] dm_addr = 32'h0;
  logic [3:0]  dm_wen = 4'h0;
  logic [31:0] dm_wdata = 32'h0;
  logic [31:0] dm_rdata;
  logic        addr_fault;
  logic        ram_ready;
  logic [31:0] test_addr = 32'h0;
  logic [31:0] test_data;

  int total = 0;
  int bad   = 0;

  logic [31:0] model_mem [DEPTH];

  always #5 clk = ~clk;

  data_ram_responder #(.AW(AW), .BASE_ADDR(BASE), .CLEAR_ON_RESET(1'b1)) dut (
    .clk        (clk),
    .reset      (reset),
    .dm_addr    (dm_addr),
    .dm_wen     (dm_wen),
    .dm_wdata   (dm_wdata),
    .dm_rdata   (dm_rdata),
    .addr_fault (addr_fault),
    .ram_ready  (ram_ready),
    .test_addr  (test_addr),
    .test_data  (test_data)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic bit in_win(input logic [31:0] a);
    longint unsigned la;
    la = longint'(a);
    return (la >= longint'(BASE)) && (la < longint'(BASE) + 4 * DEPTH);
  endfunction

  function automatic int word_of(input logic [31:0] a);
    return int'((a - BASE) / 4);
  endfunction

  task automatic model_clear();
    for (int i = 0; i < DEPTH; i++) model_mem[i] = 32'h0;
  endtask

  // One cycle: apply inputs, then check the results that appear after the edge.
  task automatic access(input logic [31:0] a, input logic [3:0] wen, input logic [31:0] wd,
                        input logic [31:0] ta, output logic [31:0] got);
    logic [31:0] exp_r, exp_t;
    logic        exp_f;
    dm_addr = a; dm_wen = wen; dm_wdata = wd; test_addr = ta;
    @(posedge clk);
    if (in_win(a)) begin
      for (int i = 0; i < 4; i++)
        if (wen[i]) model_mem[word_of(a)][8*i +: 8] = wd[8*i +: 8];
      exp_r = model_mem[word_of(a)];
      exp_f = 1'b0;
    end else begin
      exp_r = 32'h0;
      exp_f = 1'b1;
    end
    exp_t = in_win(ta) ? model_mem[word_of(ta)] : 32'h0;
    #1;
    got = dm_rdata;
    chk("rdata", dm_rdata, exp_r);
    chk("fault", {31'b0, addr_fault}, {31'b0, exp_f});
    chk("tdata", test_data, exp_t);
    chk("ready", {31'b0, ram_ready}, 32'h1);
    dm_wen = 4'h0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    dm_wen = 4'h0;
    @(posedge clk); #1;
    chk("rst_rdata", dm_rdata, 32'h0);
    chk("rst_fault", {31'b0, addr_fault}, 32'h0);
    chk("rst_tdata", test_data, 32'h0);
    chk("rst_ready", {31'b0, ram_ready}, 32'h0);
    reset = 1'b0;
  endtask

  // Counts clear cycles; a store is attempted at cycle drop_at and must be ignored.
  task automatic wait_ready(input int drop_at, input int expect_len);
    int n = 0;
    int quiet_bad = 0;
    while (ram_ready !== 1'b1 && n < 2000) begin
      dm_addr   = 32'h0;
      test_addr = 32'h0;
      dm_wdata  = 32'hDEAD_BEEF;
      dm_wen    = (n == drop_at) ? 4'hF : 4'h0;
      @(posedge clk); #1;
      n++;
      if (dm_rdata !== 32'h0 || addr_fault !== 1'b0 || test_data !== 32'h0) quiet_bad++;
    end
    dm_wen = 4'h0;
    chk("clear_len", n, expect_len);
    chk("clear_outputs_quiet", quiet_bad, 0);
    model_clear();
  endtask

  initial begin
    logic [31:0] got;
    logic [31:0] a, ta;

    do_reset();
    wait_ready(200, DEPTH);
    access(32'h0, 4'h0, 32'h0, 32'h0, got);
    chk("dropped_store", got, 32'h0);

    // Reset in the middle of a clear restarts the full sequence.
    do_reset();
    for (int i = 0; i < 100; i++) begin
      @(posedge clk); #1;
    end
    chk("midclear_not_ready", {31'b0, ram_ready}, 32'h0);
    do_reset();
    wait_ready(-1, DEPTH);

    // Byte lanes
    access(32'h10, 4'b1111, 32'hAABB_CCDD, 32'h0, got);
    access(32'h10, 4'b0100, 32'h00EE_0000, 32'h0, got);
    access(32'h10, 4'b0000, 32'h0, 32'h10, got);
    chk("byte_lanes", got, 32'hAAEE_CCDD);
    chk("byte_lanes_tdata", test_data, 32'hAAEE_CCDD);

    // Write-first merge
    access(32'h20, 4'b1111, 32'hFFFF_FFFF, 32'h0, got);
    access(32'h20, 4'b0011, 32'h0000_1234, 32'h20, got);
    chk("write_first", got, 32'hFFFF_1234);
    chk("write_first_tdata", test_data, 32'hFFFF_1234);

    // Back-to-back reads
    access(32'h0, 4'hF, 32'h1111_0000, 32'h0, got);
    access(32'h4, 4'hF, 32'h2222_0004, 32'h0, got);
    access(32'h8, 4'hF, 32'h3333_0008, 32'h0, got);
    access(32'h0, 4'h0, 32'h0, 32'h0, got);
    chk("b2b_0", got, 32'h1111_0000);
    access(32'h4, 4'h0, 32'h0, 32'h0, got);
    chk("b2b_4", got, 32'h2222_0004);
    access(32'h8, 4'h0, 32'h0, 32'h0, got);
    chk("b2b_8", got, 32'h3333_0008);

    // Window edge
    access(32'h3FC, 4'hF, 32'h5A5A_1234, 32'h0, got);
    access(32'h3FC, 4'h0, 32'h0, 32'h3FC, got);
    chk("top_word", got, 32'h5A5A_1234);
    chk("top_word_tdata", test_data, 32'h5A5A_1234);
    chk("top_word_fault", {31'b0, addr_fault}, 32'h0);
    access(32'h400, 4'h0, 32'h0, 32'h400, got);
    chk("miss_rdata", got, 32'h0);
    chk("miss_fault", {31'b0, addr_fault}, 32'h1);
    access(32'h400, 4'hF, 32'h7777_7777, 32'h0, got);
    access(32'h0, 4'h0, 32'h0, 32'h0, got);
    chk("fault_pulse_ends", {31'b0, addr_fault}, 32'h0);
    chk("no_wrap_write", got, 32'h1111_0000);

    // Randomized traffic, mostly inside the window with some misses
    for (int i = 0; i < 500; i++) begin
      a  = ($urandom_range(0, 9) == 0) ? $urandom : 32'($urandom_range(0, 32'h4FF));
      ta = ($urandom_range(0, 3) == 0) ? a : 32'($urandom_range(0, 32'h4FF));
      access(a, 4'($urandom_range(0, 15)), $urandom, ta, got);
    end

    // Full sweep of the array through the display port while the CPU port idles
    for (int i = 0; i < DEPTH; i++) begin
      access(32'h400, 4'h0, 32'h0, BASE + 32'(4 * i), got);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
